// File: rtl/reduce_pipe_nway_pkg.sv
// Shared op codes and sizing helpers for the pipelined N-way bit reduction.
package reduce_defs;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

  function automatic int unsigned levels_of(input int unsigned n);
    return $clog2(n);
  endfunction

  // Operand width entering tree level k after k ceiling-halvings.
  function automatic int unsigned width_at(input int unsigned n, input int unsigned k);
    int unsigned w;
    w = n;
    for (int unsigned i = 0; i < k; i++) w = (w + 1) / 2;
    return w;
  endfunction

  function automatic logic identity(input op_e op);
    return (op == OP_AND) || (op == OP_NAND);
  endfunction

  function automatic logic base_op(input op_e op, input logic a, input logic b);
    case (op)
      OP_AND, OP_NAND: return a & b;
      OP_OR,  OP_NOR:  return a | b;
      default:         return a ^ b;
    endcase
  endfunction

  function automatic logic is_inverting(input op_e op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

  function automatic logic is_reserved(input op_e op);
    return (op == OP_RSV6) || (op == OP_RSV7);
  endfunction

endpackage

// File: rtl/reduce_pipe_nway_stage.sv
// One tree level: pairwise-reduces its operand vector and holds valid/op/partials.
module reduce_stage
  import reduce_defs::*;
#(
  parameter  int unsigned IN_W  = 2,
  localparam int unsigned OUT_W = (IN_W + 1) / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  op_e              up_op,
  input  logic [IN_W-1:0]  up_data,
  output logic             up_ready,
  input  logic             dn_ready,
  output logic             dn_valid,
  output op_e              dn_op,
  output logic [OUT_W-1:0] dn_data
);

  logic [2*OUT_W-1:0] padded;
  logic [OUT_W-1:0]   half;

  // Odd widths get one identity leaf so the extra operand passes through unchanged.
  always_comb begin
    padded = {(2*OUT_W){identity(up_op)}};
    padded[IN_W-1:0] = up_data;
    half = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      half[i] = base_op(up_op, padded[2*i], padded[2*i+1]);
    end
  end

  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid <= 1'b0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (up_ready && up_valid) begin
      dn_op   <= up_op;
      dn_data <= half;
    end
  end

endmodule

// File: rtl/reduce_pipe_nway.sv
// Pipelined AND/OR/XOR (and inverted) reduction of NB_IN bits, one register per tree level.
module reduce_pipe_nway
  import reduce_defs::*;
#(
  parameter int unsigned NB_IN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NB_IN-1:0] in_data,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic             out_err
);

  localparam int unsigned LEVELS = levels_of(NB_IN);

  genvar k;
  for (k = 0; k < LEVELS; k++) begin : g_st
    localparam int unsigned WI = width_at(NB_IN, k);
    localparam int unsigned WO = width_at(NB_IN, k + 1);

    logic [WI-1:0] din;
    logic          vin;
    op_e           opin;
    logic          rdy_dn;
    logic [WO-1:0] dq;
    logic          vq;
    op_e           opq;
    logic          rdy_up;

    if (k == 0) begin : g_src
      assign din  = in_data;
      assign vin  = in_valid;
      assign opin = op_e'(in_op);
    end else begin : g_src
      assign din  = g_st[k-1].dq;
      assign vin  = g_st[k-1].vq;
      assign opin = g_st[k-1].opq;
    end

    if (k == LEVELS - 1) begin : g_snk
      assign rdy_dn = out_ready;
    end else begin : g_snk
      assign rdy_dn = g_st[k+1].rdy_up;
    end

    reduce_stage #(.IN_W(WI)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (vin),
      .up_op    (opin),
      .up_data  (din),
      .up_ready (rdy_up),
      .dn_ready (rdy_dn),
      .dn_valid (vq),
      .dn_op    (opq),
      .dn_data  (dq)
    );
  end

  logic last_v;
  logic last_d;
  op_e  last_op;

  assign last_v  = g_st[LEVELS-1].vq;
  assign last_d  = g_st[LEVELS-1].dq;
  assign last_op = g_st[LEVELS-1].opq;

  assign in_ready  = !rst && g_st[0].rdy_up;
  assign out_valid = last_v;
  assign out_err   = last_v && is_reserved(last_op);
  assign out_data  = last_v && !is_reserved(last_op) && (last_d ^ is_inverting(last_op));

endmodule

// File: tb/tb_reduce_pipe_nway.sv
// Bench for reduce_pipe_nway: NB_IN=8 and NB_IN=5 instances against a reduction model.
module tb_reduce_pipe_nway;
  import reduce_defs::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv   [2];
  logic       ir   [2];
  logic [7:0] dat  [2];
  logic [2:0] op   [2];
  logic       ov   [2];
  logic       ordy [2];
  logic       od   [2];
  logic       oe   [2];

  int unsigned lv [2] = '{3, 3};
  int unsigned nb [2] = '{8, 5};

  logic [1:0] fifo [2][8];
  int unsigned head [2] = '{0, 0};
  int unsigned cnt  [2] = '{0, 0};
  logic        stall [2] = '{1'b0, 1'b0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reduce_pipe_nway #(.NB_IN(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(dat[0]),
    .in_op(op[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_err(oe[0])
  );

  reduce_pipe_nway #(.NB_IN(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(dat[1][4:0]),
    .in_op(op[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_err(oe[1])
  );

  // Returns {err, data} straight from the op definitions.
  function automatic logic [1:0] model(input logic [2:0] o, input logic [7:0] d, input int unsigned n);
    logic r;
    if (o >= 3'd6) return 2'b10;
    r = (o % 3 == 0);
    for (int unsigned i = 0; i < n; i++) begin
      case (o % 3)
        0:       r = r & d[i];
        1:       r = r | d[i];
        default: r = r ^ d[i];
      endcase
    end
    if (o >= 3'd3) r = ~r;
    return {1'b0, r};
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cnt[k] = 0;
        stall[k] = 1'b0;
        chk("rst_out_valid", ov[k], 0);
        chk("rst_out_data", od[k], 0);
        chk("rst_out_err", oe[k], 0);
        chk("rst_in_ready", ir[k], 0);
      end else begin
        chk("in_ready", ir[k], (cnt[k] < lv[k]) || ordy[k]);
        if (stall[k]) chk("stall_hold_valid", ov[k], 1);
        if (ov[k]) begin
          if (cnt[k] == 0) chk("spurious_valid", ov[k], 0);
          else chk("result", {oe[k], od[k]}, fifo[k][head[k]]);
        end
        if (ov[k] && ordy[k] && cnt[k] > 0) begin
          head[k] = (head[k] + 1) % 8;
          cnt[k]--;
        end
        if (iv[k] && ir[k]) begin
          fifo[k][(head[k] + cnt[k]) % 8] = model(op[k], dat[k], nb[k]);
          cnt[k]++;
        end
        stall[k] = ov[k] && !ordy[k];
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && (cnt[0] != 0 || cnt[1] != 0); i++) @(negedge clk);
    chk("drain_dut8", cnt[0], 0);
    chk("drain_dut5", cnt[1], 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; dat[k] = '0; op[k] = '0; ordy[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", ir[0], 1);

    // NAND: FF -> 0, FE -> 1, three-edge latency
    tick();
    iv[0] = 1'b1; op[0] = OP_NAND; dat[0] = 8'hFF;
    tick();
    dat[0] = 8'hFE;
    tick();
    iv[0] = 1'b0;
    @(negedge clk); chk("nand_not_early", ov[0], 0);
    tick();
    @(negedge clk); chk("nand_ff_valid", ov[0], 1); chk("nand_ff", od[0], 0);
    tick();
    @(negedge clk); chk("nand_fe", od[0], 1);
    drain();

    // XOR stream back-to-back
    tick();
    iv[0] = 1'b1; op[0] = OP_XOR; dat[0] = 8'h01;
    @(negedge clk); chk("xor_ready0", ir[0], 1);
    tick();
    dat[0] = 8'h03;
    @(negedge clk); chk("xor_ready1", ir[0], 1);
    tick();
    dat[0] = 8'h07;
    @(negedge clk); chk("xor_ready2", ir[0], 1);
    tick();
    iv[0] = 1'b0;
    @(negedge clk); chk("xor_r0_valid", ov[0], 1); chk("xor_r0", od[0], 1);
    tick();
    @(negedge clk); chk("xor_r1_valid", ov[0], 1); chk("xor_r1", od[0], 0);
    tick();
    @(negedge clk); chk("xor_r2_valid", ov[0], 1); chk("xor_r2", od[0], 1);
    drain();

    // Backpressure: 3 of 4 AND transactions accepted, first result held
    tick();
    ordy[0] = 1'b0; iv[0] = 1'b1; op[0] = OP_AND; dat[0] = 8'hFF;
    @(negedge clk); chk("bp_ready0", ir[0], 1);
    tick();
    dat[0] = 8'h0F;
    @(negedge clk); chk("bp_ready1", ir[0], 1);
    tick();
    dat[0] = 8'hFF;
    @(negedge clk); chk("bp_ready2", ir[0], 1);
    tick();
    dat[0] = 8'h00;
    @(negedge clk); chk("bp_full", ir[0], 0); chk("bp_first_valid", ov[0], 1); chk("bp_first", od[0], 1);
    repeat (2) tick();
    @(negedge clk); chk("bp_hold", od[0], 1); chk("bp_still_full", ir[0], 0);
    tick();
    ordy[0] = 1'b1;
    @(negedge clk); chk("bp_release_ready", ir[0], 1);
    tick();
    iv[0] = 1'b0;
    drain();

    // Reserved op then OR
    tick();
    iv[0] = 1'b1; op[0] = OP_RSV6; dat[0] = 8'hAA;
    tick();
    op[0] = OP_OR; dat[0] = 8'h00;
    tick();
    iv[0] = 1'b0;
    tick();
    @(negedge clk); chk("rsv_valid", ov[0], 1); chk("rsv_data", od[0], 0); chk("rsv_err", oe[0], 1);
    tick();
    @(negedge clk); chk("or_valid", ov[0], 1); chk("or_data", od[0], 0); chk("or_err", oe[0], 0);
    drain();

    // NB_IN=5: padded leaves
    tick();
    iv[1] = 1'b1; op[1] = OP_AND; dat[1] = 8'h1F;
    tick();
    op[1] = OP_NOR; dat[1] = 8'h00;
    tick();
    op[1] = OP_XOR; dat[1] = 8'h10;
    tick();
    iv[1] = 1'b0;
    @(negedge clk); chk("n5_and_valid", ov[1], 1); chk("n5_and", od[1], 1);
    tick();
    @(negedge clk); chk("n5_nor", od[1], 1);
    tick();
    @(negedge clk); chk("n5_xor", od[1], 1);
    drain();

    // Reset with two transactions in flight
    tick();
    ordy[0] = 1'b0; iv[0] = 1'b1; op[0] = OP_OR; dat[0] = 8'h80;
    tick();
    dat[0] = 8'h01;
    tick();
    iv[0] = 1'b0;
    tick();
    @(negedge clk); chk("mid_valid", ov[0], 1);
    tick();
    rst = 1'b1;
    #1;
    chk("async_drop_valid", ov[0], 0);
    chk("async_in_ready", ir[0], 0);
    repeat (2) tick();
    rst = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk); chk("post_rst_ready", ir[0], 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk); chk("no_stale", ov[0], 0);
    end

    // Randomized traffic on both instances
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom_range(0, 9) < 7);
        op[k]   = 3'($urandom_range(0, 7));
        dat[k]  = 8'($urandom);
        ordy[k] = ($urandom_range(0, 9) < 6);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
